// File: rtl/uart_report_arbiter.sv
// uart_report_arbiter: shares one UART byte transmitter between time, date and alarm reports,
// granting latched requests by fixed priority and sending 4-byte framed snapshots.
module uart_report_arbiter #(
  parameter logic [7:0] HDR_TIME   = 8'hA1,
  parameter logic [7:0] HDR_DATE   = 8'hA2,
  parameter logic [7:0] HDR_ALARM  = 8'hA3,
  parameter int         GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_time,
  input  logic       req_date,
  input  logic       req_alarm,
  input  logic [6:0] Hour,
  input  logic [6:0] Min,
  input  logic [6:0] Sec,
  input  logic [6:0] Year,
  input  logic [6:0] Month,
  input  logic [6:0] Day,
  input  logic [6:0] Hour_out,
  input  logic [6:0] Min_out,
  input  logic [6:0] Sec_out,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [2:0] grant,
  output logic       ovf
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t st_q;
  logic [2:0] pend_q, pend_d, req, sel, grant_q;
  logic [1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic [20:0] snap_q, snap_d;
  logic [7:0] hdr, tx_data_q;
  logic tx_valid_q, ovf_q;
  // Bit order {alarm, date, time}; priority alarm > time > date.
  always_comb begin
    req = {req_alarm, req_date, req_time};
    sel = (st_q != IDLE) ? 3'b000 : pend_q[2] ? 3'b100 : pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : 3'b000;
    pend_d = (pend_q & ~sel) | req;
    snap_d = sel[2] ? {Hour_out, Min_out, Sec_out} : sel[0] ? {Hour, Min, Sec} : {Year, Month, Day};
    hdr = sel[2] ? HDR_ALARM : sel[0] ? HDR_TIME : HDR_DATE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      pend_q <= '0;
      grant_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
      snap_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (|(req & pend_q)) ovf_q <= 1'b1;
      case (st_q)
        IDLE: if (|sel) begin
          grant_q <= sel;
          snap_q <= snap_d;
          tx_data_q <= hdr;
          tx_valid_q <= 1'b1;
          idx_q <= '0;
          st_q <= SEND;
        end
        SEND: if (tx_ready) begin
          if (idx_q == 2'd3) begin
            tx_valid_q <= 1'b0;
            grant_q <= '0;
            gap_q <= GW'(GAP_CYCLES - 1);
            st_q <= GAP;
          end else begin
            idx_q <= idx_q + 2'd1;
            tx_data_q <= {1'b0, idx_q == 2'd0 ? snap_q[20:14] : idx_q == 2'd1 ? snap_q[13:7] : snap_q[6:0]};
          end
        end
        GAP: if (gap_q == '0) st_q <= IDLE; else gap_q <= gap_q - 1'b1;
        default: st_q <= IDLE;
      endcase
    end
  end
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant = grant_q;
  assign ovf = ovf_q;
  assign busy = st_q != IDLE;
endmodule

// File: doc/uart_report_arbiter.md
Name: uart_report_arbiter

Overview:
- Shares the single UART byte transmitter between three report sources: current time, calendar date and alarm-fire event.
- Latches report requests as pending and grants one at a time by fixed priority.
- Snapshots the payload at grant, then sequences a 4-byte frame over a valid/ready byte handshake.
- Sits between the clock/calendar/alarm units and the serial send path.

Parameters:
- HDR_TIME, 8'hA1, header byte of a time frame.
- HDR_DATE, 8'hA2, header byte of a date frame.
- HDR_ALARM, 8'hA3, header byte of an alarm-event frame.
- GAP_CYCLES, 16, idle clk cycles after a frame before the next grant (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_time  input  1  single-cycle pulse: request a time report.
- req_date  input  1  single-cycle pulse: request a date report.
- req_alarm  input  1  single-cycle pulse: request an alarm-event report.
- Hour, Min, Sec  input  7 each  current time values.
- Year, Month, Day  input  7 each  current date values.
- Hour_out, Min_out, Sec_out  input  7 each  alarm setting values.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts the byte this cycle.
- busy  output  1  high in SEND or GAP.
- grant  output  3  one-hot active source {alarm, date, time}; 0 when not in SEND.
- ovf  output  1  sticky: a request arrived while the same source was already pending.

Behaviour:
- Reset (synchronous, any state, including mid-frame):
  - tx_valid=0, tx_data=0, busy=0, grant=0, ovf=0.
  - All pending bits cleared, FSM to IDLE, byte index=0, gap counter=0.
  - An in-flight frame is abandoned; no partial resume.
- Pending latch:
  - A request pulse seen at edge k sets pending[src] at edge k.
  - If the source was already pending, or is being granted at the same edge, set ovf.
  - When a grant and a new request for the same source coincide, pending stays set, so the source is re-served later.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any pending bit is set at edge k+1, pick the source by priority alarm > time > date.
  - Clear that pending bit and latch a payload snapshot of three 7-bit values:
    - time: Hour, Min, Sec
    - date: Year, Month, Day
    - alarm: Hour_out, Min_out, Sec_out
  - Set grant, tx_data=header, tx_valid=1, index=0, go to SEND.
  - First byte is visible the cycle after the request's pending bit is set (2 cycles after the request pulse).
- SEND:
  - Frame is byte0=header, then {1'b0,v0}, {1'b0,v1}, {1'b0,v2}.
  - Transfer occurs on any edge where tx_valid && tx_ready. The index then advances and the next byte is driven the following cycle, with no bubble.
  - tx_valid and tx_data must hold stable while tx_ready=0.
  - The snapshot is immune to input changes mid-frame.
  - After the byte-3 transfer: tx_valid=0, grant=0, load gap counter = GAP_CYCLES-1, go to GAP.
- GAP:
  - Decrement the counter; at 0, go to IDLE.
  - Requests during SEND and GAP are latched as pending, not lost.
- busy=1 in SEND and GAP; grant is one-hot only in SEND.
- With tx_ready held high, a frame occupies 4 cycles, followed by GAP_CYCLES cycles before the next grant can occur in IDLE.
- No starvation guarantee for date under continuous higher-priority traffic. This is acceptable: time requests arrive at 1 Hz.

Test Plan:
- req_time pulse at cycle 0, tx_ready=1, time 12:34:56 → tx_valid cycles 2-5 with bytes A1,0C,22,38; grant=001 during them; busy through the gap; IDLE after 16 gap cycles.
- req_alarm, req_time, req_date on the same cycle → frames in order A3, A1, A2; each next header appears exactly GAP_CYCLES+1 cycles after the previous frame's last transfer; ovf=0.
- tx_ready low for 5 cycles while byte1 is presented → tx_data stays at byte1 and tx_valid stays 1; the frame completes 5 cycles later than with tx_ready=1; no byte duplicated or skipped.
- Sec changes 56→57 during SEND → frame still carries 38 (56); a req_time during GAP yields a second frame with 39 (57).
- Two req_time pulses while one is pending (before grant) → ovf=1 and stays 1; only one time frame is sent.
- reset asserted on byte2 of a date frame, with req_time pending → next cycle tx_valid=0, grant=0, ovf=0, no pending; no frame follows until a new request.
